text_scroller: RTL and testbench
================================

TEXT_SCROLLER -- requirements
Module: text_scroller

Interface
REQ-001 Parameters (name, default, meaning): X0, 140, left pixel of text box; Y0, 224, top line of text box; H_ACTIVE, 640, visible width and scroll wrap modulus; SPEED, 1, pixels of scroll added per frame.
REQ-002 Ports (name direction width meaning):
- clk input 1: pixel clock; single clock domain.
- rst_n input 1: asynchronous, active-low reset.
- hpos input 10: current horizontal pixel position.
- vpos input 10: current vertical line position.
- display_on input 1: visible-area flag.
- hsync_in input 1: horizontal sync.
- vsync_in input 1: vertical sync.
- char_code output 8: ASCII code sent to the 5x7 font ROM.
- rom_row output 3: font row sent to the ROM.
- rom_col output 3: font column sent to the ROM.
- rom_pixel input 1: combinational ROM pixel for the current char_code/rom_row/rom_col.
- pixel_out output 1: text pixel, aligned with the delayed syncs.
- hsync_out output 1: hsync_in delayed 2 cycles.
- vsync_out output 1: vsync_in delayed 2 cycles.
- de_out output 1: display_on delayed 2 cycles.

Function
REQ-003 Message, fixed 15 chars, index 0..14: "Driving IT 2025" = 44 72 69 76 69 6E 67 20 49 54 20 32 30 32 35 (hex).
REQ-004 Font scale 4x: one font pixel is 4x4 screen pixels; character cell is 24 px wide (5 font cols + 1 gap col) and 28 lines tall.
REQ-005 Effective x = hpos + scroll_off; if the sum >= H_ACTIVE, subtract H_ACTIVE (one subtraction only; sum is computed 11-bit).
REQ-006 Box coordinates: rel_x = x_eff - X0; rel_y = vpos - Y0.
REQ-007 in_text is true iff 0 <= rel_x < 360 and 0 <= rel_y < 28.
REQ-008 Cell decode: char index = rel_x / 24; cell col = (rel_x mod 24) / 4 (0..5); rom_row = rel_y / 4.
REQ-009 Cell col 5 is the gap column; rom_col is forced to 0 and the pixel is masked.
REQ-010 Stage 1 (registered): char_code, rom_row, rom_col, in_text, gap, and the three input syncs/display_on are registered together. When not in_text, char_code = 8'h20 and rom_row = rom_col = 0.
REQ-011 Stage 2 (registered): pixel_out = rom_pixel & in_text_q & !gap_q & display_on_q; sync and de outputs are the stage-1 copies re-registered.
REQ-012 Latency: exactly 2 clk cycles from (hpos, vpos, syncs, display_on) to pixel_out, hsync_out, vsync_out and de_out.
REQ-013 Frame tick: a rising edge of vsync_in, detected against a registered copy of vsync_in.
REQ-014 On a frame tick: scroll_off <= (scroll_off + SPEED) mod H_ACTIVE. The new value is first used for the pixel sampled on the next cycle.
REQ-015 scroll_off is 10 bits; SPEED < H_ACTIVE is required; the wrap subtracts H_ACTIVE once.

Reset
REQ-016 While rst_n is low, all outputs and internal registers are 0 (including scroll_off and the vsync edge register), except char_code, which is 8'h20.
REQ-017 Reset asserted mid-frame clears the pipeline immediately (asynchronously).
REQ-018 After rst_n is released, valid outputs appear after 2 cycles, and no frame tick occurs in the first cycle.

Configuration
REQ-019 Macro TEXT_SCROLL_EN.
- Defined: scroll_off and frame-tick logic behave per REQ-013 to REQ-015.
- Undefined: scroll_off is constant 0, no scroll registers are synthesized, and the text is static at X0.

Verification
REQ-020 Static glyph: reset, hpos=140, vpos=224, display_on=1 -> 1 cycle later char_code=0x44, rom_row=0, rom_col=0; 2 cycles later pixel_out=1.
REQ-021 Gap and next char: hpos=160 -> pixel_out=0 (gap); hpos=164 -> char_code=0x72, rom_col=0, and pixel_out=0 ('r' row 0 is blank).
REQ-022 Scroll (TEXT_SCROLL_EN): 3 vsync_in rising edges -> scroll_off=3; then hpos=137, vpos=224 -> char_code=0x44, pixel_out=1.
REQ-023 Wrap: after 639 frame ticks, scroll_off=639; next tick -> 0. With scroll_off=1 and hpos=639: x_eff=0, so in_text=0, char_code=0x20.
REQ-024 Masking and sync latency:
- display_on=0 inside the box -> pixel_out=0, de_out=0.
- A single-cycle hsync_in pulse appears on hsync_out exactly 2 cycles later.
- rst_n pulsed low mid-line -> all outputs 0 at once.

Source files
------------

// File: rtl/text_scroller.sv
// text_scroller: renders the fixed 15-character message "Driving IT 2025"
// at 4x font scale inside a 360x28 box at (X0, Y0), optionally scrolling it
// horizontally by SPEED pixels per frame.
//
// Two-stage pipeline:
//   stage 1 registers the font ROM address (char_code/rom_row/rom_col),
//           the in-box and gap flags, and the input syncs/display_on;
//   stage 2 registers the ROM pixel (masked) and the delayed syncs.
//
// Ports:
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   hpos, vpos            current raster position
//   display_on            visible-area flag
//   hsync_in, vsync_in    raster syncs
//   char_code, rom_row,   font ROM address (registered, stage 1)
//   rom_col
//   rom_pixel             combinational ROM data for the registered address
//   pixel_out             text pixel (2-cycle latency)
//   hsync_out, vsync_out, de_out   inputs delayed by 2 cycles
//
// Configuration macro: TEXT_SCROLL_EN
//   defined   - scroll offset advances on each rising edge of vsync_in
//   undefined - scroll offset is constant 0, text is static at X0
module text_scroller #(
    parameter int unsigned X0       = 140,
    parameter int unsigned Y0       = 224,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned SPEED    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [7:0] char_code,
    output logic [2:0] rom_row,
    output logic [2:0] rom_col,
    input  logic       rom_pixel,
    output logic       pixel_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       de_out
);

    localparam int unsigned TEXT_W = 360;  // 15 cells x 24 px
    localparam int unsigned TEXT_H = 28;   // 7 font rows x 4 lines
    localparam logic [7:0]  SPACE  = 8'h20;

    function automatic logic [7:0] msg_char(input logic [3:0] idx);
        logic [7:0] c;
        case (idx)
            4'd0:    c = 8'h44;  // D
            4'd1:    c = 8'h72;  // r
            4'd2:    c = 8'h69;  // i
            4'd3:    c = 8'h76;  // v
            4'd4:    c = 8'h69;  // i
            4'd5:    c = 8'h6E;  // n
            4'd6:    c = 8'h67;  // g
            4'd7:    c = 8'h20;
            4'd8:    c = 8'h49;  // I
            4'd9:    c = 8'h54;  // T
            4'd10:   c = 8'h20;
            4'd11:   c = 8'h32;  // 2
            4'd12:   c = 8'h30;  // 0
            4'd13:   c = 8'h32;  // 2
            4'd14:   c = 8'h35;  // 5
            default: c = SPACE;
        endcase
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Scroll offset
    // ------------------------------------------------------------------
    logic [9:0] scroll_off;

`ifdef TEXT_SCROLL_EN
    logic [9:0]  scroll_off_q, scroll_off_d;
    logic        vsync_prev_q, vsync_prev_d;
    logic        armed_q, armed_d;
    logic        frame_tick;
    logic [10:0] scroll_sum;

    // armed_q suppresses a tick in the first cycle after reset, when
    // vsync_prev_q is still 0 even though vsync_in may already be high.
    always_comb begin
        vsync_prev_d = vsync_in;
        armed_d      = 1'b1;
        frame_tick   = vsync_in & ~vsync_prev_q & armed_q;
        scroll_sum   = {1'b0, scroll_off_q} + 11'(SPEED);
        scroll_off_d = scroll_off_q;
        if (frame_tick) begin
            if (scroll_sum >= 11'(H_ACTIVE))
                scroll_off_d = 10'(scroll_sum - 11'(H_ACTIVE));
            else
                scroll_off_d = scroll_sum[9:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scroll_off_q <= '0;
            vsync_prev_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            scroll_off_q <= scroll_off_d;
            vsync_prev_q <= vsync_prev_d;
            armed_q      <= armed_d;
        end
    end

    assign scroll_off = scroll_off_q;
`else
    assign scroll_off = '0;
`endif

    // ------------------------------------------------------------------
    // Coordinate decode
    // ------------------------------------------------------------------
    logic [10:0] x_sum, x_eff;
    logic [8:0]  rel_x;
    logic [4:0]  rel_y;
    logic [8:0]  char_idx9;
    logic [4:0]  cell_x;
    logic [2:0]  cell_col;
    logic        in_x, in_y, in_text, gap;

    always_comb begin
        x_sum = {1'b0, hpos} + {1'b0, scroll_off};
        x_eff = (x_sum >= 11'(H_ACTIVE)) ? (x_sum - 11'(H_ACTIVE)) : x_sum;
        in_x  = (x_eff >= 11'(X0)) && (x_eff < 11'(X0 + TEXT_W));
        in_y  = (vpos >= 10'(Y0)) && (vpos < 10'(Y0 + TEXT_H));
        // Offsets are only meaningful inside the box, so truncating to the
        // box extent is safe.
        rel_x     = 9'(x_eff - 11'(X0));
        rel_y     = 5'(vpos - 10'(Y0));
        char_idx9 = rel_x / 9'd24;
        cell_x    = 5'(rel_x % 9'd24);
        cell_col  = 3'(cell_x >> 2);
        in_text   = in_x && in_y;
        gap       = in_text && (cell_col == 3'd5);
    end

    // ------------------------------------------------------------------
    // Stage 1
    // ------------------------------------------------------------------
    logic [7:0] char_code_q, char_code_d;
    logic [2:0] rom_row_q, rom_row_d;
    logic [2:0] rom_col_q, rom_col_d;
    logic       in_text_q, in_text_d;
    logic       gap_q, gap_d;
    logic       hsync1_q, hsync1_d;
    logic       vsync1_q, vsync1_d;
    logic       de1_q, de1_d;

    always_comb begin
        char_code_d = SPACE;
        rom_row_d   = '0;
        rom_col_d   = '0;
        in_text_d   = in_text;
        gap_d       = gap;
        hsync1_d    = hsync_in;
        vsync1_d    = vsync_in;
        de1_d       = display_on;
        if (in_text) begin
            char_code_d = msg_char(char_idx9[3:0]);
            rom_row_d   = 3'(rel_y >> 2);
            rom_col_d   = gap ? 3'd0 : cell_col;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_code_q <= SPACE;
            rom_row_q   <= '0;
            rom_col_q   <= '0;
            in_text_q   <= 1'b0;
            gap_q       <= 1'b0;
            hsync1_q    <= 1'b0;
            vsync1_q    <= 1'b0;
            de1_q       <= 1'b0;
        end else begin
            char_code_q <= char_code_d;
            rom_row_q   <= rom_row_d;
            rom_col_q   <= rom_col_d;
            in_text_q   <= in_text_d;
            gap_q       <= gap_d;
            hsync1_q    <= hsync1_d;
            vsync1_q    <= vsync1_d;
            de1_q       <= de1_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2
    // ------------------------------------------------------------------
    logic pixel_q, pixel_d;
    logic hsync2_q, hsync2_d;
    logic vsync2_q, vsync2_d;
    logic de2_q, de2_d;

    always_comb begin
        pixel_d  = rom_pixel & in_text_q & ~gap_q & de1_q;
        hsync2_d = hsync1_q;
        vsync2_d = vsync1_q;
        de2_d    = de1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_q  <= 1'b0;
            hsync2_q <= 1'b0;
            vsync2_q <= 1'b0;
            de2_q    <= 1'b0;
        end else begin
            pixel_q  <= pixel_d;
            hsync2_q <= hsync2_d;
            vsync2_q <= vsync2_d;
            de2_q    <= de2_d;
        end
    end

    assign char_code = char_code_q;
    assign rom_row   = rom_row_q;
    assign rom_col   = rom_col_q;
    assign pixel_out = pixel_q;
    assign hsync_out = hsync2_q;
    assign vsync_out = vsync2_q;
    assign de_out    = de2_q;

endmodule

// File: tb/tb_text_scroller.sv
// Directed self-checking bench for text_scroller with a small font ROM
// model covering the glyphs 'D' and 'r'.
module tb_text_scroller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hpos, vpos;
    logic       display_on, hsync_in, vsync_in;
    logic [7:0] char_code;
    logic [2:0] rom_row, rom_col;
    logic       rom_pixel;
    logic       pixel_out, hsync_out, vsync_out, de_out;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    text_scroller #(
        .X0(140), .Y0(224), .H_ACTIVE(640), .SPEED(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos),
        .display_on(display_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .char_code(char_code), .rom_row(rom_row), .rom_col(rom_col),
        .rom_pixel(rom_pixel), .pixel_out(pixel_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out)
    );

    function automatic logic font_px(input logic [7:0] c, input logic [2:0] r,
                                     input logic [2:0] col);
        logic [4:0] bits;
        bits = '0;
        if (c == 8'h44) begin
            case (r)
                3'd0, 3'd6:       bits = 5'b11100;
                3'd1, 3'd5:       bits = 5'b10010;
                3'd2, 3'd3, 3'd4: bits = 5'b10001;
                default:          bits = '0;
            endcase
        end else if (c == 8'h72) begin
            case (r)
                3'd2:             bits = 5'b10110;
                3'd3:             bits = 5'b11001;
                3'd4, 3'd5, 3'd6: bits = 5'b10000;
                default:          bits = '0;
            endcase
        end
        if (col > 3'd4) return 1'b0;
        return bits[3'd4 - col];
    endfunction

    always_comb rom_pixel = font_px(char_code, rom_row, rom_col);

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [9:0] h, input logic [9:0] v,
                         input logic de, input logic hs);
        @(negedge clk);
        hpos = h; vpos = v; display_on = de; hsync_in = hs;
    endtask

    task automatic settle();
        @(posedge clk); @(posedge clk); #1;
    endtask

    task automatic frame_tick();
        @(negedge clk); vsync_in = 1'b1;
        @(negedge clk); vsync_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic probe(input string name, input logic [9:0] h,
                         input logic [7:0] exp_ch, input logic exp_pix);
        drive(h, 10'd224, 1'b1, 1'b0);
        settle();
        check({name, "_char"}, char_code, exp_ch);
        check({name, "_pix"}, 8'(pixel_out), 8'(exp_pix));
    endtask

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       de;
        logic       hs;
        logic [7:0] ch;
        logic [2:0] row;
        logic [2:0] col;
        logic       pix;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{10'd140, 10'd224, 1'b1, 1'b0, 8'h44, 3'd0, 3'd0, 1'b1};
        vecs[1]  = '{10'd160, 10'd224, 1'b1, 1'b0, 8'h44, 3'd0, 3'd0, 1'b0};
        vecs[2]  = '{10'd164, 10'd224, 1'b1, 1'b1, 8'h72, 3'd0, 3'd0, 1'b0};
        vecs[3]  = '{10'd152, 10'd228, 1'b1, 1'b0, 8'h44, 3'd1, 3'd3, 1'b1};
        vecs[4]  = '{10'd172, 10'd232, 1'b1, 1'b0, 8'h72, 3'd2, 3'd2, 1'b1};
        vecs[5]  = '{10'd140, 10'd224, 1'b0, 1'b0, 8'h44, 3'd0, 3'd0, 1'b0};
        vecs[6]  = '{10'd139, 10'd224, 1'b1, 1'b0, 8'h20, 3'd0, 3'd0, 1'b0};
        vecs[7]  = '{10'd500, 10'd224, 1'b1, 1'b0, 8'h20, 3'd0, 3'd0, 1'b0};
        vecs[8]  = '{10'd499, 10'd224, 1'b1, 1'b0, 8'h35, 3'd0, 3'd0, 1'b0};
        vecs[9]  = '{10'd140, 10'd251, 1'b1, 1'b0, 8'h44, 3'd6, 3'd0, 1'b1};
        vecs[10] = '{10'd140, 10'd252, 1'b1, 1'b0, 8'h20, 3'd0, 3'd0, 1'b0};
        vecs[11] = '{10'd140, 10'd223, 1'b1, 1'b0, 8'h20, 3'd0, 3'd0, 1'b0};
        vecs[12] = '{10'd332, 10'd224, 1'b1, 1'b0, 8'h49, 3'd0, 3'd0, 1'b0};
        vecs[13] = '{10'd380, 10'd229, 1'b1, 1'b1, 8'h20, 3'd1, 3'd0, 1'b0};
        vecs[14] = '{10'd476, 10'd244, 1'b1, 1'b0, 8'h35, 3'd5, 3'd0, 1'b0};
        vecs[15] = '{10'd148, 10'd236, 1'b1, 1'b0, 8'h44, 3'd3, 3'd2, 1'b0};

        // Reset with busy inputs
        rst_n = 1'b0;
        hpos = 10'd140; vpos = 10'd224;
        display_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_char", char_code, 8'h20);
        check("rst_row", 8'(rom_row), 8'd0);
        check("rst_col", 8'(rom_col), 8'd0);
        check("rst_pix", 8'(pixel_out), 8'd0);
        check("rst_hs", 8'(hsync_out), 8'd0);
        check("rst_vs", 8'(vsync_out), 8'd0);
        check("rst_de", 8'(de_out), 8'd0);

        // Release with vsync_in already high: no frame tick may follow
        @(negedge clk);
        rst_n = 1'b1; hsync_in = 1'b0;
        @(posedge clk); #1;
        check("rel1_char", char_code, 8'h44);
        check("rel1_pix", 8'(pixel_out), 8'd0);
        check("rel1_vs", 8'(vsync_out), 8'd0);
        @(posedge clk); #1;
        check("rel2_pix", 8'(pixel_out), 8'd1);
        check("rel2_vs", 8'(vsync_out), 8'd1);
        @(negedge clk); vsync_in = 1'b0;
        repeat (3) @(posedge clk);
        probe("no_tick_139", 10'd139, 8'h20, 1'b0);

        // Table of steady-state vectors
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].h, vecs[i].v, vecs[i].de, vecs[i].hs);
            settle();
            check($sformatf("v%0d_char", i), char_code, vecs[i].ch);
            check($sformatf("v%0d_row", i), 8'(rom_row), 8'(vecs[i].row));
            check($sformatf("v%0d_col", i), 8'(rom_col), 8'(vecs[i].col));
            check($sformatf("v%0d_pix", i), 8'(pixel_out), 8'(vecs[i].pix));
            check($sformatf("v%0d_hs", i), 8'(hsync_out), 8'(vecs[i].hs));
            check($sformatf("v%0d_de", i), 8'(de_out), 8'(vecs[i].de));
            check($sformatf("v%0d_vs", i), 8'(vsync_out), 8'd0);
        end

        // Single-cycle hsync pulse: exactly 2 cycles of latency
        drive(10'd0, 10'd0, 1'b0, 1'b0);
        settle();
        @(negedge clk); hsync_in = 1'b1;
        @(negedge clk); hsync_in = 1'b0;
        #1 check("hs_pulse_c1", 8'(hsync_out), 8'd0);
        @(posedge clk); #1;
        check("hs_pulse_c2", 8'(hsync_out), 8'd1);
        @(posedge clk); #1;
        check("hs_pulse_c3", 8'(hsync_out), 8'd0);

        // Asynchronous reset mid-line
        drive(10'd140, 10'd224, 1'b1, 1'b1);
        settle();
        check("pre_rst_pix", 8'(pixel_out), 8'd1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_char", char_code, 8'h20);
        check("async_pix", 8'(pixel_out), 8'd0);
        check("async_hs", 8'(hsync_out), 8'd0);
        check("async_de", 8'(de_out), 8'd0);
        @(negedge clk); rst_n = 1'b1; hsync_in = 1'b0;

`ifdef TEXT_SCROLL_EN
        // Three frame ticks shift the text left by 3 pixels
        repeat (3) frame_tick();
        probe("scr3_137", 10'd137, 8'h44, 1'b1);
        probe("scr3_136", 10'd136, 8'h20, 1'b0);
        // Advance to offset 639, then wrap to 0 and 1
        repeat (636) frame_tick();
        probe("scr639_500", 10'd500, 8'h35, 1'b0);
        probe("scr639_141", 10'd141, 8'h44, 1'b1);
        probe("scr639_140", 10'd140, 8'h20, 1'b0);
        frame_tick();
        probe("scr0_140", 10'd140, 8'h44, 1'b1);
        probe("scr0_139", 10'd139, 8'h20, 1'b0);
        frame_tick();
        probe("scr1_639", 10'd639, 8'h20, 1'b0);
        probe("scr1_139", 10'd139, 8'h44, 1'b1);
`else
        // Static text: frame ticks do not move it
        repeat (3) frame_tick();
        probe("static_137", 10'd137, 8'h20, 1'b0);
        probe("static_140", 10'd140, 8'h44, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
